// File: rtl/rrf_manager.sv
// Rename register file manager: per-entry busy/valid/data state, the free bitmap,
// result writeback, operand lookup with writeback bypass, and commit release.
module rrf_manager #(
    parameter int NUM_RRF = 8,
    parameter int TAG_W   = 3,
    parameter int DATA_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alloc0_en,
    input  logic [TAG_W-1:0]    alloc0_tag,
    input  logic                alloc1_en,
    input  logic [TAG_W-1:0]    alloc1_tag,
    input  logic                wb0_en,
    input  logic [TAG_W-1:0]    wb0_tag,
    input  logic [DATA_W-1:0]   wb0_data,
    input  logic                wb1_en,
    input  logic [TAG_W-1:0]    wb1_tag,
    input  logic [DATA_W-1:0]   wb1_data,
    input  logic [TAG_W-1:0]    rd0_tag,
    output logic [DATA_W-1:0]   rd0_data,
    output logic                rd0_ready,
    input  logic [TAG_W-1:0]    rd1_tag,
    output logic [DATA_W-1:0]   rd1_data,
    output logic                rd1_ready,
    input  logic                ret0_en,
    input  logic [TAG_W-1:0]    ret0_tag,
    output logic [DATA_W-1:0]   ret0_data,
    input  logic                ret1_en,
    input  logic [TAG_W-1:0]    ret1_tag,
    output logic [DATA_W-1:0]   ret1_data,
    input  logic                flush,
    output logic [0:NUM_RRF-1]  free_rrf,
    output logic [TAG_W:0]      free_count,
    output logic                rrf_full,
    output logic                err
);

    logic [NUM_RRF-1:0] r_busy, r_valid, w_busy_nxt, w_valid_nxt;
    logic [DATA_W-1:0]  r_data     [NUM_RRF];
    logic [DATA_W-1:0]  w_data_nxt [NUM_RRF];
    logic [TAG_W:0]     r_free_count, w_free_count_nxt;
    logic               r_full, r_err, w_err_set;

    // Protocol violations, all judged against pre-edge entry state.
    always_comb begin
        w_err_set = 1'b0;
        if (alloc0_en && r_busy[alloc0_tag]) w_err_set = 1'b1;
        if (alloc1_en && r_busy[alloc1_tag]) w_err_set = 1'b1;
        if (alloc0_en && alloc1_en && alloc0_tag == alloc1_tag) w_err_set = 1'b1;
        if (wb0_en && !r_busy[wb0_tag]) w_err_set = 1'b1;
        if (wb1_en && !r_busy[wb1_tag]) w_err_set = 1'b1;
        if (wb0_en && wb1_en && wb0_tag == wb1_tag) w_err_set = 1'b1;
        if (ret0_en && !r_valid[ret0_tag]) w_err_set = 1'b1;
        if (ret1_en && !r_valid[ret1_tag]) w_err_set = 1'b1;
        if (ret0_en && ret1_en && ret0_tag == ret1_tag) w_err_set = 1'b1;
    end

    // An ignored (illegal) request never blocks a lower-priority legal one.
    always_comb begin
        w_busy_nxt       = r_busy;
        w_valid_nxt      = r_valid;
        w_free_count_nxt = '0;
        for (int unsigned j = 0; j < NUM_RRF; j++) begin
            w_data_nxt[j] = r_data[j];
            if (flush) begin
                w_busy_nxt[j]  = 1'b0;
                w_valid_nxt[j] = 1'b0;
            end else if (r_valid[j] && ((ret0_en && ret0_tag == TAG_W'(j)) ||
                                        (ret1_en && ret1_tag == TAG_W'(j)))) begin
                w_busy_nxt[j]  = 1'b0;
                w_valid_nxt[j] = 1'b0;
            end else if (r_busy[j] && ((wb0_en && wb0_tag == TAG_W'(j)) ||
                                       (wb1_en && wb1_tag == TAG_W'(j)))) begin
                w_valid_nxt[j] = 1'b1;
                w_data_nxt[j]  = (wb1_en && wb1_tag == TAG_W'(j)) ? wb1_data : wb0_data;
            end else if (!r_busy[j] && ((alloc0_en && alloc0_tag == TAG_W'(j)) ||
                                        (alloc1_en && alloc1_tag == TAG_W'(j)))) begin
                w_busy_nxt[j] = 1'b1;
            end
            w_free_count_nxt = w_free_count_nxt + {{TAG_W{1'b0}}, ~w_busy_nxt[j]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy       <= '0;
            r_valid      <= '0;
            r_free_count <= (TAG_W+1)'(NUM_RRF);
            r_full       <= 1'b0;
            r_err        <= 1'b0;
            for (int unsigned j = 0; j < NUM_RRF; j++) r_data[j] <= '0;
        end else begin
            r_busy       <= w_busy_nxt;
            r_valid      <= w_valid_nxt;
            r_free_count <= w_free_count_nxt;
            r_full       <= (w_free_count_nxt < (TAG_W+1)'(2));
            r_err        <= r_err | (w_err_set & ~flush);
            for (int unsigned j = 0; j < NUM_RRF; j++) r_data[j] <= w_data_nxt[j];
        end
    end

    always_comb begin
        for (int unsigned j = 0; j < NUM_RRF; j++) free_rrf[j] = ~r_busy[j];
    end

    assign free_count = r_free_count;
    assign rrf_full   = r_full;
    assign err        = r_err;
    assign ret0_data  = r_data[ret0_tag];
    assign ret1_data  = r_data[ret1_tag];

    // Writeback bypass: port 1 outranks port 0, then the stored entry.
    always_comb begin
        if (wb1_en && wb1_tag == rd0_tag) begin
            rd0_data = wb1_data;  rd0_ready = 1'b1;
        end else if (wb0_en && wb0_tag == rd0_tag) begin
            rd0_data = wb0_data;  rd0_ready = 1'b1;
        end else begin
            rd0_data = r_data[rd0_tag];  rd0_ready = r_valid[rd0_tag];
        end
        if (wb1_en && wb1_tag == rd1_tag) begin
            rd1_data = wb1_data;  rd1_ready = 1'b1;
        end else if (wb0_en && wb0_tag == rd1_tag) begin
            rd1_data = wb0_data;  rd1_ready = 1'b1;
        end else begin
            rd1_data = r_data[rd1_tag];  rd1_ready = r_valid[rd1_tag];
        end
    end

endmodule

// File: tb/tb_rrf_manager.sv
// Scenario-driven bench for rrf_manager: expectations are queued as stimulus is
// applied and popped when the corresponding DUT output is sampled.
module tb_rrf_manager;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alloc0_en, alloc1_en, wb0_en, wb1_en, ret0_en, ret1_en, flush;
    logic [2:0]  alloc0_tag, alloc1_tag, wb0_tag, wb1_tag, rd0_tag, rd1_tag, ret0_tag, ret1_tag;
    logic [15:0] wb0_data, wb1_data, rd0_data, rd1_data, ret0_data, ret1_data;
    logic        rd0_ready, rd1_ready, rrf_full, err;
    logic [0:7]  free_rrf;
    logic [3:0]  free_count;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;

    rrf_manager #(.NUM_RRF(8), .TAG_W(3), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc0_en(alloc0_en), .alloc0_tag(alloc0_tag),
        .alloc1_en(alloc1_en), .alloc1_tag(alloc1_tag),
        .wb0_en(wb0_en), .wb0_tag(wb0_tag), .wb0_data(wb0_data),
        .wb1_en(wb1_en), .wb1_tag(wb1_tag), .wb1_data(wb1_data),
        .rd0_tag(rd0_tag), .rd0_data(rd0_data), .rd0_ready(rd0_ready),
        .rd1_tag(rd1_tag), .rd1_data(rd1_data), .rd1_ready(rd1_ready),
        .ret0_en(ret0_en), .ret0_tag(ret0_tag), .ret0_data(ret0_data),
        .ret1_en(ret1_en), .ret1_tag(ret1_tag), .ret1_data(ret1_data),
        .flush(flush), .free_rrf(free_rrf), .free_count(free_count),
        .rrf_full(rrf_full), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] mk(logic [0:7] f, int unsigned cnt, logic full, logic er);
        return {18'b0, f, 4'(cnt), full, er};
    endfunction

    function automatic logic [31:0] stat();
        return {18'b0, free_rrf, free_count, rrf_full, err};
    endfunction

    task automatic idle();
        alloc0_en = 0; alloc1_en = 0; wb0_en = 0; wb1_en = 0;
        ret0_en = 0; ret1_en = 0; flush = 0;
        alloc0_tag = 0; alloc1_tag = 0; wb0_tag = 0; wb1_tag = 0;
        ret0_tag = 0; ret1_tag = 0; wb0_data = 0; wb1_data = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        sb.push_back('{"por_status", mk(8'b1111_1111, 8, 0, 0)});
        e = sb.pop_front(); n_cmp++;
        if (stat() !== e.exp) begin n_err++; $display("FAIL %s: got %h, expected %h", e.name, stat(), e.exp); end

        alloc0_en = 1; alloc0_tag = 3; alloc1_en = 1; alloc1_tag = 5;
        sb.push_back('{"midop_alloc", mk(8'b1110_1011, 6, 0, 0)});
        step();
        e = sb.pop_front(); n_cmp++;
        if (stat() !== e.exp) begin n_err++; $display("FAIL %s: got %h, expected %h", e.name, stat(), e.exp); end

        wb0_en = 1; wb0_tag = 3; wb0_data = 16'h1234;
        sb.push_back('{"midop_wb_rd", {15'b0, 1'b1, 16'h1234}});
        step();
        rd0_tag = 3;
        #1;
        e = sb.pop_front(); n_cmp++;
        if ({15'b0, rd0_ready, rd0_data} !== e.exp) begin n_err++; $display("FAIL %s: got %h, expected %h", e.name, {rd0_ready, rd0_data}, e.exp); end

        rst_n = 1'b0;
        sb.push_back('{"async_reset_status", mk(8'b1111_1111, 8, 0, 0)});
        #1;
        e = sb.pop_front(); n_cmp++;
        if (stat() !== e.exp) begin n_err++; $display("FAIL %s: got %h, expected %h", e.name, stat(), e.exp); end
        for (int t = 0; t < 8; t++) begin
            rd0_tag = 3'(t); rd1_tag = 3'(7 - t);
            sb.push_back('{"reset_rd_ready", 32'b0});
            #1;
            e = sb.pop_front(); n_cmp++;
            if ({30'b0, rd0_ready, rd1_ready} !== e.exp) begin n_err++; $display("FAIL %s[%0d]: got %b%b, expected 00", e.name, t, rd0_ready, rd1_ready); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_lifecycle();
        do_reset();
        alloc0_en = 1; alloc0_tag = 0; alloc1_en = 1; alloc1_tag = 1;
        sb.push_back('{"life_alloc", mk(8'b0011_1111, 6, 0, 0)});
        step();
        e = sb.pop_front(); n_cmp++;
        if (stat() !== e.exp) begin n_err++; $display("FAIL %s: got %h, expected %h", e.name, stat(), e.exp); end

        wb0_en = 1; wb0_tag = 0; wb0_data = 16'hABCD;
        sb.push_back('{"life_rd_after_wb", {15'b0, 1'b1, 16'hABCD}});
        step();
        rd0_tag = 0;
        #1;
        e = sb.pop_front(); n_cmp++;
        if ({15'b0, rd0_ready, rd0_data} !== e.exp) begin n_err++; $display("FAIL %s: got %h, expected %h", e.name, {rd0_ready, rd0_data}, e.exp); end

        ret0_en = 1; ret0_tag = 0;
        sb.push_back('{"life_ret_data", {16'b0, 16'hABCD}});
        #1;
        e = sb.pop_front(); n_cmp++;
        if ({16'b0, ret0_data} !== e.exp) begin n_err++; $display("FAIL %s: got %h, expected %h", e.name, ret0_data, e.exp); end

        sb.push_back('{"life_retire", mk(8'b1011_1111, 7, 0, 0)});
        step();
        e = sb.pop_front(); n_cmp++;
        if (stat() !== e.exp) begin n_err++; $display("FAIL %s: got %h, expected %h", e.name, stat(), e.exp); end
    endtask

    task automatic test_full();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            alloc0_en = 1; alloc0_tag = 3'(2 * c); alloc1_en = 1; alloc1_tag = 3'(2 * c + 1);
            step();
        end
        alloc0_en = 1; alloc0_tag = 6;
        sb.push_back('{"full_one_left", mk(8'b0000_0001, 1, 1, 0)});
        step();
        e = sb.pop_front(); n_cmp++;
        if (stat() !== e.exp) begin n_err++; $display("FAIL %s: got %h, expected %h", e.name, stat(), e.exp); end

        wb0_en = 1; wb0_tag = 2; wb0_data = 16'h0022;
        step();
        ret0_en = 1; ret0_tag = 2;
        sb.push_back('{"full_retire_two", mk(8'b0010_0001, 2, 0, 0)});
        step();
        e = sb.pop_front(); n_cmp++;
        if (stat() !== e.exp) begin n_err++; $display("FAIL %s: got %h, expected %h", e.name, stat(), e.exp); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        alloc0_en = 1; alloc0_tag = 2;
        step();
        wb0_en = 1; wb0_tag = 2; wb0_data = 16'h5555;
        step();
        ret0_en = 1; ret0_tag = 2; alloc1_en = 1; alloc1_tag = 4;
        sb.push_back('{"same_ret_alloc", mk(8'b1111_0111, 7, 0, 0)});
        step();
        e = sb.pop_front(); n_cmp++;
        if (stat() !== e.exp) begin n_err++; $display("FAIL %s: got %h, expected %h", e.name, stat(), e.exp); end

        alloc0_en = 1; alloc0_tag = 2;
        sb.push_back('{"realloc_tag2", mk(8'b1101_0111, 6, 0, 0)});
        step();
        e = sb.pop_front(); n_cmp++;
        if (stat() !== e.exp) begin n_err++; $display("FAIL %s: got %h, expected %h", e.name, stat(), e.exp); end

        alloc0_en = 1; alloc0_tag = 2;
        sb.push_back('{"alloc_busy_err", mk(8'b1101_0111, 6, 0, 1)});
        step();
        e = sb.pop_front(); n_cmp++;
        if (stat() !== e.exp) begin n_err++; $display("FAIL %s: got %h, expected %h", e.name, stat(), e.exp); end

        sb.push_back('{"err_sticky", mk(8'b1101_0111, 6, 0, 1)});
        step();
        e = sb.pop_front(); n_cmp++;
        if (stat() !== e.exp) begin n_err++; $display("FAIL %s: got %h, expected %h", e.name, stat(), e.exp); end
    endtask

    task automatic test_bypass();
        do_reset();
        alloc0_en = 1; alloc0_tag = 5;
        step();
        rd0_tag = 5; rd1_tag = 6; wb1_en = 1; wb1_tag = 5; wb1_data = 16'h0042;
        sb.push_back('{"bypass_rd0", {15'b0, 1'b1, 16'h0042}});
        sb.push_back('{"bypass_rd1_free", 32'b0});
        #1;
        e = sb.pop_front(); n_cmp++;
        if ({15'b0, rd0_ready, rd0_data} !== e.exp) begin n_err++; $display("FAIL %s: got %h, expected %h", e.name, {rd0_ready, rd0_data}, e.exp); end
        e = sb.pop_front(); n_cmp++;
        if ({15'b0, rd1_ready, rd1_data} !== e.exp) begin n_err++; $display("FAIL %s: got %h, expected %h", e.name, {rd1_ready, rd1_data}, e.exp); end

        sb.push_back('{"bypass_stored", {15'b0, 1'b1, 16'h0042}});
        sb.push_back('{"bypass_status", mk(8'b1111_1011, 7, 0, 0)});
        step();
        #1;
        e = sb.pop_front(); n_cmp++;
        if ({15'b0, rd0_ready, rd0_data} !== e.exp) begin n_err++; $display("FAIL %s: got %h, expected %h", e.name, {rd0_ready, rd0_data}, e.exp); end
        e = sb.pop_front(); n_cmp++;
        if (stat() !== e.exp) begin n_err++; $display("FAIL %s: got %h, expected %h", e.name, stat(), e.exp); end
    endtask

    task automatic test_wb_conflict();
        do_reset();
        alloc0_en = 1; alloc0_tag = 1;
        step();
        rd0_tag = 1; wb0_en = 1; wb0_tag = 1; wb0_data = 16'h1111;
        wb1_en = 1; wb1_tag = 1; wb1_data = 16'h2222;
        sb.push_back('{"wb_conflict_bypass", {15'b0, 1'b1, 16'h2222}});
        #1;
        e = sb.pop_front(); n_cmp++;
        if ({15'b0, rd0_ready, rd0_data} !== e.exp) begin n_err++; $display("FAIL %s: got %h, expected %h", e.name, {rd0_ready, rd0_data}, e.exp); end

        sb.push_back('{"wb_conflict_stored", {15'b0, 1'b1, 16'h2222}});
        sb.push_back('{"wb_conflict_status", mk(8'b1011_1111, 7, 0, 1)});
        step();
        #1;
        e = sb.pop_front(); n_cmp++;
        if ({15'b0, rd0_ready, rd0_data} !== e.exp) begin n_err++; $display("FAIL %s: got %h, expected %h", e.name, {rd0_ready, rd0_data}, e.exp); end
        e = sb.pop_front(); n_cmp++;
        if (stat() !== e.exp) begin n_err++; $display("FAIL %s: got %h, expected %h", e.name, stat(), e.exp); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            alloc0_en = 1; alloc0_tag = 3'(2 * c); alloc1_en = 1; alloc1_tag = 3'(2 * c + 1);
            step();
        end
        sb.push_back('{"flush_pre", mk(8'b0000_0011, 2, 0, 0)});
        e = sb.pop_front(); n_cmp++;
        if (stat() !== e.exp) begin n_err++; $display("FAIL %s: got %h, expected %h", e.name, stat(), e.exp); end

        flush = 1; alloc0_en = 1; alloc0_tag = 7;
        sb.push_back('{"flush_post", mk(8'b1111_1111, 8, 0, 0)});
        step();
        e = sb.pop_front(); n_cmp++;
        if (stat() !== e.exp) begin n_err++; $display("FAIL %s: got %h, expected %h", e.name, stat(), e.exp); end

        alloc0_en = 1; alloc0_tag = 7;
        sb.push_back('{"flush_realloc7", mk(8'b1111_1110, 7, 0, 0)});
        step();
        e = sb.pop_front(); n_cmp++;
        if (stat() !== e.exp) begin n_err++; $display("FAIL %s: got %h, expected %h", e.name, stat(), e.exp); end
    endtask

    initial begin
        idle();
        rd0_tag = 0; rd1_tag = 0;
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        step();
        test_reset();
        test_lifecycle();
        test_full();
        test_same_cycle();
        test_bypass();
        test_wb_conflict();
        test_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rrf_manager.md
Name: rrf_manager

Overview:
- Owns the 8-entry rename register file (RRF): per-entry busy/valid state, result data, and the free bitmap.
- The rename stage consumes the free bitmap to pick up to two tags per cycle and allocates them back here.
- Execution units write results into allocated entries. Commit (ROB) reads results and releases entries back to the free pool.
- Flush returns every entry to the free pool.

Parameters:
NUM_RRF, 8, number of RRF entries
TAG_W, 3, tag width (log2 NUM_RRF)
DATA_W, 16, result data width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
alloc0_en  in  1  rename allocates alloc0_tag this cycle
alloc0_tag  in  TAG_W  first allocated tag
alloc1_en  in  1  rename allocates alloc1_tag this cycle
alloc1_tag  in  TAG_W  second allocated tag
wb0_en  in  1  execution result write, port 0
wb0_tag  in  TAG_W  destination entry, port 0
wb0_data  in  DATA_W  result, port 0
wb1_en, wb1_tag, wb1_data  in  1/TAG_W/DATA_W  same, port 1
rd0_tag  in  TAG_W  operand lookup tag, port 0
rd0_data  out  DATA_W  entry data, with wb bypass, port 0
rd0_ready  out  1  entry valid, or bypassed this cycle, port 0
rd1_tag, rd1_data, rd1_ready  in/out/out  TAG_W/DATA_W/1  same, port 1
ret0_en  in  1  commit releases ret0_tag
ret0_tag  in  TAG_W  released entry, port 0
ret0_data  out  DATA_W  data[ret0_tag], combinational, for ARF write
ret1_en, ret1_tag, ret1_data  in/in/out  1/TAG_W/DATA_W  same, port 1
flush  in  1  synchronous: free all entries
free_rrf  out  [0:NUM_RRF-1]  bit j=1 means entry j free (registered)
free_count  out  TAG_W+1  number of free entries (registered)
rrf_full  out  1  free_count < 2 (registered)
err  out  1  sticky protocol-violation flag

Behaviour:
- Entry states:
  - FREE: busy=0, valid=0.
  - ALLOC: busy=1, valid=0.
  - DONE: busy=1, valid=1.
- Transitions occur on the rising edge and are evaluated against pre-edge state.
- Reset (async, rst_n=0):
  - All entries FREE, data 0.
  - free_rrf all ones, free_count=NUM_RRF, rrf_full=0, err=0.
  - Combinational outputs follow reset state.
- Priority per entry in one cycle: flush > retire > writeback > alloc.
- flush=1: all entries FREE, free_count=NUM_RRF next cycle. All other requests that cycle are ignored. err is unchanged.
- Alloc:
  - FREE -> ALLOC.
  - Alloc of a non-FREE entry: ignored, err<=1.
  - alloc0_tag==alloc1_tag with both enables: one allocation only, err<=1.
- Writeback:
  - ALLOC -> DONE, data<=wb_data.
  - Writeback to a FREE entry: ignored, err<=1.
  - Writeback to a DONE entry: data overwritten, no error.
  - wb0/wb1 to the same tag: wb1 wins, err<=1.
- Retire:
  - DONE -> FREE; data is retained but becomes don't-care.
  - Retire of a non-DONE entry: ignored, err<=1.
  - ret0/ret1 to the same tag: single release, err<=1.
- Same-cycle alloc and retire of the same tag: retire applies, alloc is ignored, err<=1 (the entry was busy pre-edge).
- Same-cycle retire of X and alloc of a different free Y: both apply.
- Bitmap and count:
  - free_rrf, free_count and rrf_full reflect post-edge state. Latency is 1 cycle from any alloc/retire/flush.
  - free_count = popcount(free_rrf), range 0..NUM_RRF.
  - rrf_full=1 when fewer than 2 entries are free (rename needs two tags per cycle).
- Read ports (combinational):
  - If wbN_en and wbN_tag==rd_tag, return wb data with ready=1; wb1 has priority over wb0.
  - Otherwise return data[rd_tag], with ready=valid.
- ret_data is combinational data[ret_tag], with no bypass.
- err clears only on reset.

Test Plan:
- Reset mid-operation:
  - Stimulus: allocate 3,5 and write back 3, then pulse rst_n low asynchronously between edges.
  - Response: free_rrf=8'b1111_1111, free_count=8, rrf_full=0 and err=0 immediately; rd_ready=0 for all tags.
- Full lifecycle:
  - Stimulus: alloc0 tag0, alloc1 tag1; next cycle wb0 tag0=16'hABCD; next cycle retire tag0.
  - Response: free_rrf bits 0,1 go to 0 after the 1st edge; rd0(tag0) ready=1, data ABCD after the 2nd edge; ret0_data=ABCD in the retire cycle; bit0=1 after the 3rd edge; err=0.
- Full boundary:
  - Stimulus: allocate tags 0..6 over 4 cycles.
  - Response: free_count=1, rrf_full=1. Then retire one DONE entry -> free_count=2, rrf_full=0.
- Same-cycle events:
  - Stimulus A: retire tag2 (DONE) together with alloc tag4 (FREE) -> bit2=1, bit4=0, err=0.
  - Stimulus B: alloc of busy tag2 -> ignored, err=1 and stays 1.
- Bypass:
  - Stimulus: rd0_tag=5 while wb1_en with tag5=16'h0042.
  - Response: rd0_data=0042, rd0_ready=1 in the same cycle.
- Flush:
  - Stimulus: 6 entries busy; assert flush with simultaneous alloc of tag7.
  - Response: next cycle free_rrf all ones, free_count=8, tag7 free.
